effect_noise_gate: RTL and testbench

- Noise gate stage that sits directly upstream of the EQ effect in the per-sample effect chain.
- Consumes ADC samples under a one-cycle valid strobe and tracks a peak envelope.
- Smoothly mutes the signal when the envelope stays below a selectable threshold, using a ramped gain and a hold timer to avoid clicks and chatter.
- Output uses the same strobe/data convention as the rest of the chain, so it feeds the EQ with no glue logic.

---
 rtl/effect_pkg.sv | 30 +++
 rtl/gate_envelope.sv | 43 ++++
 rtl/effect_noise_gate.sv | 140 ++++++++++++++
 tb/tb_effect_noise_gate.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/effect_pkg.sv
// Shared types and constants for the effect chain.
// Holds the noise-gate state encoding, the unity gain and the threshold table.
package effect_pkg;

    typedef enum logic [2:0] {
        GATE_CLOSED  = 3'd0,
        GATE_ATTACK  = 3'd1,
        GATE_OPEN    = 3'd2,
        GATE_HOLD    = 3'd3,
        GATE_RELEASE = 3'd4
    } gate_state_t;

    localparam logic [8:0] GATE_GAIN_UNITY = 9'd256;

    function automatic logic [15:0] gate_open_thr(input logic [2:0] level);
        logic [15:0] thr;
        case (level)
            3'd0:    thr = 16'd0;
            3'd1:    thr = 16'd64;
            3'd2:    thr = 16'd128;
            3'd3:    thr = 16'd256;
            3'd4:    thr = 16'd512;
            3'd5:    thr = 16'd1024;
            3'd6:    thr = 16'd2048;
            default: thr = 16'd4096;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/gate_envelope.sv
// Magnitude and peak-follower envelope for the noise gate.
// Instant attack to the sample magnitude, exponential decay by ENV_SHIFT.
module gate_envelope #(
    parameter int ENV_SHIFT = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic signed [15:0] i_sample,
    output logic        [15:0] o_env,
    output logic        [15:0] o_env_next
);

    logic [15:0] r_env;
    logic [15:0] w_mag;

    // -32768 has no positive counterpart in 16 bits, so it folds to 32767
    always_comb begin
        if (i_sample == 16'sh8000)
            w_mag = 16'h7fff;
        else if (i_sample[15])
            w_mag = $unsigned(-i_sample);
        else
            w_mag = $unsigned(i_sample);
    end

    always_comb begin
        if (w_mag > r_env)
            o_env_next = w_mag;
        else
            o_env_next = r_env - (r_env >> ENV_SHIFT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_env <= '0;
        else if (i_valid)
            r_env <= o_env_next;
    end

    assign o_env = r_env;

endmodule

// File: rtl/effect_noise_gate.sv
// Noise gate stage: envelope-driven gain ramp with hold timer, 1-cycle latency.
// All state advances only on i_valid; i_enable=0 bypasses and parks the gate OPEN.
module effect_noise_gate
    import effect_pkg::*;
#(
    parameter int ENV_SHIFT    = 6,
    parameter int HOLD_SAMPLES = 2048,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic               i_enable,
    input  logic        [2:0]  i_level_thresh,
    input  logic signed [15:0] i_data,
    output logic signed [15:0] o_data,
    output logic               o_valid,
    output logic        [2:0]  o_gate_state
);

    localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    gate_state_t        r_state, w_state_nxt;
    logic [8:0]         r_gain, w_gain_nxt;
    logic [HOLD_W-1:0]  r_hold, w_hold_nxt;

    logic [15:0]        w_env, w_env_next;
    logic [15:0]        w_open_thr, w_close_thr;
    logic               w_env_open, w_env_low;
    logic [9:0]         w_gain_up;
    logic [8:0]         w_gain_up_sat, w_gain_dn;
    logic signed [24:0] w_prod;
    logic signed [15:0] w_data_nxt;

    gate_envelope #(.ENV_SHIFT(ENV_SHIFT)) u_env (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .i_sample   (i_data),
        .o_env      (w_env),
        .o_env_next (w_env_next)
    );

    assign w_open_thr  = gate_open_thr(i_level_thresh);
    assign w_close_thr = w_open_thr >> 1;
    assign w_env_open  = (w_env_next >= w_open_thr);
    assign w_env_low   = (w_env_next <  w_close_thr);

    assign w_gain_up     = {1'b0, r_gain} + 10'(ATTACK_STEP);
    assign w_gain_up_sat = (w_gain_up >= {1'b0, GATE_GAIN_UNITY}) ? GATE_GAIN_UNITY : w_gain_up[8:0];
    assign w_gain_dn     = (r_gain <= 9'(RELEASE_STEP)) ? 9'd0 : r_gain - 9'(RELEASE_STEP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= GATE_CLOSED;
            r_gain  <= '0;
            r_hold  <= '0;
        end else if (i_valid) begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_hold_nxt  = r_hold;
        if (!i_enable) begin
            w_state_nxt = GATE_OPEN;
            w_gain_nxt  = GATE_GAIN_UNITY;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                GATE_CLOSED: begin
                    if (w_env_open) begin
                        w_state_nxt = GATE_ATTACK;
                        w_gain_nxt  = 9'(ATTACK_STEP);
                    end
                end
                GATE_ATTACK: begin
                    w_gain_nxt = w_gain_up_sat;
                    if (w_gain_up >= {1'b0, GATE_GAIN_UNITY})
                        w_state_nxt = GATE_OPEN;
                end
                GATE_OPEN: begin
                    w_gain_nxt = GATE_GAIN_UNITY;
                    if (w_env_low) begin
                        w_state_nxt = GATE_HOLD;
                        w_hold_nxt  = HOLD_W'(HOLD_SAMPLES - 1);
                    end
                end
                GATE_HOLD: begin
                    if (w_env_open)
                        w_state_nxt = GATE_OPEN;
                    else if (r_hold == '0)
                        w_state_nxt = GATE_RELEASE;
                    else
                        w_hold_nxt = r_hold - 1'b1;
                end
                GATE_RELEASE: begin
                    // re-trigger ramps up from wherever the release had got to
                    if (w_env_open) begin
                        w_state_nxt = GATE_ATTACK;
                        w_gain_nxt  = w_gain_up_sat;
                    end else begin
                        w_gain_nxt = w_gain_dn;
                        if (w_gain_dn == 9'd0)
                            w_state_nxt = GATE_CLOSED;
                    end
                end
                default: begin
                    w_state_nxt = GATE_CLOSED;
                    w_gain_nxt  = '0;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    // output uses the gain from before this sample's update
    always_comb begin
        w_prod       = $signed(25'(i_data)) * $signed(25'({1'b0, r_gain}));
        w_data_nxt   = i_enable ? w_prod[23:8] : i_data;
        o_gate_state = r_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid)
                o_data <= w_data_nxt;
        end
    end

endmodule

// File: tb/tb_effect_noise_gate.sv
// Scoreboard bench for effect_noise_gate: stimulus pushes model results, monitor pops and compares.
module tb_effect_noise_gate;
    import effect_pkg::*;

    localparam int ENV_SHIFT = 6;
    localparam int HOLD      = 4;
    localparam int AS        = 16;
    localparam int RS        = 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               vld = 1'b0;
    logic               en = 1'b1;
    logic        [2:0]  lvl = 3'd0;
    logic signed [15:0] din = '0;
    logic signed [15:0] dout;
    logic               ov;
    logic        [2:0]  gst;

    always #5 clk = ~clk;

    effect_noise_gate #(
        .ENV_SHIFT(ENV_SHIFT), .HOLD_SAMPLES(HOLD), .ATTACK_STEP(AS), .RELEASE_STEP(RS)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld), .i_enable(en),
        .i_level_thresh(lvl), .i_data(din),
        .o_data(dout), .o_valid(ov), .o_gate_state(gst)
    );

    typedef struct { int data; int st; } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // reference model: plain integer view of the gate
    int m_env = 0, m_gain = 0, m_st = 0, m_hold = 0;
    localparam int S_CLOSED = 0, S_ATTACK = 1, S_OPEN = 2, S_HOLD = 3, S_RELEASE = 4;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_env = 0; m_gain = 0; m_st = S_CLOSED; m_hold = 0;
    endtask

    task automatic model_step(input int x, input bit e, input int l, output int out);
        int mag, envn, open_t, close_t;
        mag = (x < 0) ? -x : x;
        if (mag > 32767) mag = 32767;
        envn = (mag > m_env) ? mag : m_env - (m_env >> ENV_SHIFT);
        open_t  = (l == 0) ? 0 : (32 << l);
        close_t = open_t / 2;
        out = e ? ((x * m_gain) >>> 8) : x;
        if (!e) begin
            m_st = S_OPEN; m_gain = 256; m_hold = 0;
        end else begin
            case (m_st)
                S_CLOSED: if (envn >= open_t) begin m_st = S_ATTACK; m_gain = AS; end
                S_ATTACK: begin
                    m_gain += AS;
                    if (m_gain >= 256) begin m_gain = 256; m_st = S_OPEN; end
                end
                S_OPEN: begin
                    m_gain = 256;
                    if (envn < close_t) begin m_st = S_HOLD; m_hold = HOLD - 1; end
                end
                S_HOLD: begin
                    if (envn >= open_t) m_st = S_OPEN;
                    else if (m_hold == 0) m_st = S_RELEASE;
                    else m_hold--;
                end
                default: begin
                    if (envn >= open_t) begin
                        m_st = S_ATTACK;
                        m_gain = (m_gain + AS > 256) ? 256 : m_gain + AS;
                    end else begin
                        m_gain = (m_gain - RS < 0) ? 0 : m_gain - RS;
                        if (m_gain == 0) m_st = S_CLOSED;
                    end
                end
            endcase
        end
        m_env = envn;
    endtask

    task automatic issue(input int x, input int gap);
        int out;
        exp_t ex;
        @(posedge clk); #1;
        din = 16'(x);
        vld = 1'b1;
        model_step(x, en, int'(lvl), out);
        ex.data = out;
        ex.st   = m_st;
        q.push_back(ex);
        @(posedge clk); #1;
        vld = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    // monitor
    logic v_d;
    int   last_d = 0;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) v_d <= 1'b0;
        else        v_d <= vld;

    always @(negedge clk) begin
        exp_t ex;
        if (!rst_n) begin
            last_d = 0;
        end else begin
            check("o_valid_timing", int'(ov), int'(v_d));
            if (ov) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    ex = q.pop_front();
                    check("o_data", int'(dout), ex.data);
                    check("o_gate_state", int'(gst), ex.st);
                end
                last_d = int'(dout);
            end else begin
                check("o_data_hold", int'(dout), last_d);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rnd, loud, n;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_data", int'(dout), 0);
        check("reset_o_valid", int'(ov), 0);
        check("reset_state", int'(gst), int'(GATE_CLOSED));
        rst_n = 1'b1;

        // constant +1000 at level 3: 16-sample attack
        en = 1'b1; lvl = 3'd3;
        for (int k = 1; k <= 1000; k++) begin
            issue(1000, 0);
            if (k == 1)  check("attack_s1", int'(dout), 0);
            if (k == 2)  check("attack_s2", int'(dout), 62);
            if (k == 15) check("attack_s15_state", int'(gst), int'(GATE_ATTACK));
            if (k == 16) check("attack_s16_state", int'(gst), int'(GATE_OPEN));
            if (k == 17) check("attack_s17", int'(dout), 1000);
        end

        // zeros: open -> hold -> release -> closed
        n = 0;
        while (m_st != S_CLOSED && n < 2000) begin issue(0, 0); n++; end
        check("decay_reached_closed", int'(m_st == S_CLOSED), 1);
        check("closed_state", int'(gst), int'(GATE_CLOSED));

        // re-open, then re-trigger during release at gain 100
        for (int k = 0; k < 20; k++) issue(1000, 0);
        n = 0;
        while (!(m_st == S_RELEASE && m_gain == 100) && n < 3000) begin issue(0, 0); n++; end
        check("reached_release_100", int'(m_st == S_RELEASE && m_gain == 100), 1);
        issue(8000, 0);
        check("retrigger_out", int'(dout), 3125);
        check("retrigger_state", int'(gst), int'(GATE_ATTACK));
        issue(1000, 0);
        check("retrigger_gain116", int'(dout), 453);

        // bypass
        en = 1'b0; lvl = 3'd7;
        issue(-32768, 0);
        check("bypass_neg", int'(dout), -32768);
        check("bypass_state", int'(gst), int'(GATE_OPEN));
        issue(5, 0);
        check("bypass_5", int'(dout), 5);

        // sparse valid: one sample every 8 cycles
        en = 1'b1; lvl = 3'd2;
        for (int k = 0; k < 40; k++) begin
            rnd = int'($urandom_range(0, 4000)) - 2000;
            issue((k % 10 < 5) ? rnd : rnd / 64, 6);
        end

        // randomized mix of loud bursts, quiet noise, level and enable changes
        loud = 1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) loud = ~loud & 1;
            if ($urandom_range(0, 99) == 0) lvl = 3'($urandom_range(0, 7));
            en = ($urandom_range(0, 29) != 0);
            if (loud != 0) rnd = int'($urandom_range(0, 65535)) - 32768;
            else           rnd = int'($urandom_range(0, 60)) - 30;
            if ($urandom_range(0, 199) == 0) rnd = -32768;
            issue(rnd, int'($urandom_range(0, 3)));
        end

        // async reset in the middle of an attack ramp
        en = 1'b1; lvl = 3'd3;
        n = 0;
        while (m_st != S_CLOSED && n < 3000) begin issue(0, 0); n++; end
        check("pre_reset_closed", int'(gst), int'(GATE_CLOSED));
        for (int k = 0; k < 3; k++) issue(1000, 0);
        check("pre_reset_attack", int'(gst), int'(GATE_ATTACK));
        @(negedge clk); #1;
        @(posedge clk); #1;
        din = 16'sd1000; vld = 1'b1;
        @(posedge clk); #2;
        vld = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_o_data", int'(dout), 0);
        check("async_rst_o_valid", int'(ov), 0);
        check("async_rst_state", int'(gst), int'(GATE_CLOSED));
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        issue(1000, 0);
        check("post_reset_first", int'(dout), 0);
        issue(1000, 2);

        check("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
